// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide engine with internal HI/LO.
// One shared adder serves both the add-shift multiply and the restoring
// shift-subtract divide; signed ops run on magnitudes and are sign-fixed
// in a final cycle before HI/LO are written.
module muldiv_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DZ} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_is_div, r_neg_res, r_neg_rem;
    logic [WIDTH-1:0]   r_mb;              // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   r_acc;             // product upper half or partial remainder
    logic [WIDTH-1:0]   r_q;               // multiplier bits or dividend/quotient bits
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done, r_div_zero;
    logic [WIDTH-1:0]   r_hi, r_lo;

    logic               w_accept, w_last, w_fix_wr, w_dz_hit;
    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_shift, w_add_x, w_add_y, w_sum;
    logic [WIDTH-1:0]   w_acc_nxt, w_q_nxt;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;
    logic [WIDTH-1:0]   w_quo, w_rem, w_hi_fix, w_lo_fix;

    // abort in IDLE swallows a simultaneous start
    assign w_accept = (r_state == S_IDLE) && start && !abort;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_fix_wr = (r_state == S_FIX) && !abort;
    assign w_dz_hit = (r_state == S_DZ) && !abort;

    // Operand magnitudes; the most-negative value maps onto 2^(WIDTH-1), which is exact unsigned
    assign w_a_neg = !op[0] && a[WIDTH-1];
    assign w_b_neg = !op[0] && b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    // Shared adder: divide computes (remainder<<1 | next bit) - divisor, multiply adds the multiplicand
    assign w_shift = {r_acc, r_q[WIDTH-1]};
    assign w_add_x = r_is_div ? w_shift : {1'b0, r_acc};
    assign w_add_y = r_is_div ? ~{1'b0, r_mb} : (r_q[0] ? {1'b0, r_mb} : '0);
    assign w_sum   = w_add_x + w_add_y + {{WIDTH{1'b0}}, r_is_div};

    // One radix-2 step; for divide a clear MSB of the difference means no borrow, so keep it
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        w_acc_nxt = w_sum[WIDTH:1];
        w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
        if (r_is_div) begin
            w_acc_nxt = w_sum[WIDTH] ? w_shift[WIDTH-1:0] : w_sum[WIDTH-1:0];
            w_q_nxt   = {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
        end
    end

    // Sign correction: quotient/product follow the operand sign xor, remainder follows the dividend
    assign w_prod     = {r_acc, r_q};
    assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
    assign w_quo      = r_neg_res ? -r_q : r_q;
    assign w_rem      = r_neg_rem ? -r_acc : r_acc;
    assign w_hi_fix   = r_is_div ? w_rem : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_lo_fix   = r_is_div ? w_quo : w_prod_fix[WIDTH-1:0];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; abort returns any busy state to IDLE
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = (op[1] && (b == '0)) ? S_DZ : S_RUN;
            S_RUN:  if (abort) w_state_nxt = S_IDLE;
                    else if (w_last) w_state_nxt = S_FIX;
            S_FIX:  w_state_nxt = S_IDLE;
            S_DZ:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand latch on accept, then one iteration per RUN cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_mb      <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_is_div  <= op[1];
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_mb      <= op[1] ? w_b_mag : w_a_mag;
            r_q       <= op[1] ? w_a_mag : w_b_mag;
            r_acc     <= '0;
            r_cnt     <= '0;
        end else if (r_state == S_RUN) begin
            r_acc     <= w_acc_nxt;
            r_q       <= w_q_nxt;
            r_cnt     <= r_cnt + CNT_W'(1);
        end
    end

    // Result registers and completion pulses; HI/LO move only on a FIX write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_done     <= w_fix_wr | w_dz_hit;
            r_div_zero <= w_dz_hit;
            if (w_fix_wr) begin
                r_hi <= w_hi_fix;
                r_lo <= w_lo_fix;
            end
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit (WIDTH=32 plus a WIDTH=8 instance).
module tb_muldiv_unit;

    localparam int W  = 32;
    localparam int W8 = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, abort;
    logic [1:0]    op;
    logic [W-1:0]  a, b;
    logic          busy, done, div_zero;
    logic [W-1:0]  hi, lo;

    logic          start8, abort8;
    logic [1:0]    op8;
    logic [W8-1:0] a8, b8;
    logic          busy8, done8, div_zero8;
    logic [W8-1:0] hi8, lo8;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    logic [W-1:0] last_hi, last_lo;
    int           checks = 0;
    int           errors = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .abort(abort),
        .a(a), .b(b), .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(W8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .abort(abort8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .div_zero(div_zero8),
        .hi(hi8), .lo(lo8)
    );

    always #5 clk = ~clk;

    // Reference model built on native 64-bit arithmetic
    function automatic exp_t model(input logic [1:0] m_op, input logic [W-1:0] m_a, m_b,
                                   input logic [W-1:0] p_hi, p_lo);
        exp_t           r;
        longint         sa, sbv, qs, rs;
        logic [2*W-1:0] p;
        sa   = longint'($signed(m_a));
        sbv  = longint'($signed(m_b));
        r.dz = 1'b0;
        r.hi = p_hi;
        r.lo = p_lo;
        case (m_op)
            2'b00: begin
                p = sa * sbv;
                r.hi = p[2*W-1:W];
                r.lo = p[W-1:0];
            end
            2'b01: begin
                p = {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};
                r.hi = p[2*W-1:W];
                r.lo = p[W-1:0];
            end
            2'b10: begin
                if (m_b == '0) r.dz = 1'b1;
                else begin
                    qs = sa / sbv;
                    rs = sa % sbv;
                    r.lo = qs[W-1:0];
                    r.hi = rs[W-1:0];
                end
            end
            default: begin
                if (m_b == '0) r.dz = 1'b1;
                else begin
                    r.lo = m_a / m_b;
                    r.hi = m_a % m_b;
                end
            end
        endcase
        return r;
    endfunction

    // Scoreboard: every done pulse is matched against the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done got hi=%h lo=%h dz=%b, wanted no done", hi, lo, div_zero);
            end else begin
                mon_e = sb_q.pop_front();
                if (hi !== mon_e.hi || lo !== mon_e.lo || div_zero !== mon_e.dz) begin
                    errors++;
                    $display("FAIL sb_result got hi=%h lo=%h dz=%b, wanted hi=%h lo=%h dz=%b",
                             hi, lo, div_zero, mon_e.hi, mon_e.lo, mon_e.dz);
                end
            end
        end
    end

    // Present one start pulse at the current negedge; inputs are scrambled once it has been sampled
    task automatic issue(input logic [1:0] i_op, input logic [W-1:0] i_a, i_b, input bit track);
        exp_t e;
        op    = i_op;
        a     = i_a;
        b     = i_b;
        start = 1'b1;
        if (track) begin
            e = model(i_op, i_a, i_b, last_hi, last_lo);
            sb_q.push_back(e);
            last_hi = e.hi;
            last_lo = e.lo;
        end
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom);
    endtask

    // Bounded wait for done; lat stays -1 if the budget runs out
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0; abort = 1'b0; op = 2'b00; a = '0; b = '0;
        start8 = 1'b0; abort8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        last_hi = '0; last_lo = '0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b wanted 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b wanted 0", done); end
        checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b wanted 0", div_zero); end
        checks++; if (hi !== '0 || lo !== '0) begin errors++; $display("FAIL reset_hilo got %h/%h wanted 0/0", hi, lo); end
        checks++; if (busy8 !== 1'b0 || hi8 !== '0 || lo8 !== '0) begin
            errors++; $display("FAIL reset_w8 got busy=%b hi=%h lo=%h wanted 0", busy8, hi8, lo8);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_release got busy=%b done=%b wanted 0/0", busy, done);
        end
    endtask

    task automatic test_mult_signed();
        int lat; bit bok;
        issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1);
        wait_done(lat, bok);
        checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency got %0d wanted 33", lat); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL mult_busy got low wanted high"); end
        checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++; $display("FAIL mult_result got %h_%h wanted ffffffff_ffffffeb", hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int lat; bit bok;
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done(lat, bok);
        checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency got %0d wanted 33", lat); end
        checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h1) begin
            errors++; $display("FAIL multu_result got %h_%h wanted fffffffe_00000001", hi, lo);
        end
        // start presented while done is high
        issue(2'b11, 32'd100, 32'd7, 1'b1);
        wait_done(lat, bok);
        checks++; if (lat !== 33 || bok !== 1'b1) begin
            errors++; $display("FAIL b2b_latency got %0d busy_ok=%b wanted 33/1", lat, bok);
        end
        checks++; if (hi !== 32'd2 || lo !== 32'd14) begin
            errors++; $display("FAIL divu_result got hi=%0d lo=%0d wanted 2/14", hi, lo);
        end
    endtask

    task automatic test_div_zero();
        int lat; bit bok;
        issue(2'b10, 32'd5, 32'd0, 1'b1);
        wait_done(lat, bok);
        checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency got %0d wanted 1", lat); end
        checks++; if (div_zero !== 1'b1 || hi !== 32'd2 || lo !== 32'd14) begin
            errors++; $display("FAIL dz_result got dz=%b hi=%0d lo=%0d wanted 1/2/14", div_zero, hi, lo);
        end
        @(negedge clk);
        checks++; if (done !== 1'b0 || div_zero !== 1'b0) begin
            errors++; $display("FAIL dz_pulse got done=%b dz=%b wanted 0/0", done, div_zero);
        end
    endtask

    task automatic test_div_signed();
        int lat; bit bok;
        logic [1:0]   r_op;
        logic [W-1:0] r_a, r_b;
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done(lat, bok);
        checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency got %0d wanted 33", lat); end
        checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL div_neg got hi=%h lo=%h wanted ffffffff/fffffffd", hi, lo);
        end
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(lat, bok);
        checks++; if (hi !== 32'h0 || lo !== 32'h8000_0000 || div_zero !== 1'b0) begin
            errors++; $display("FAIL div_ovf got hi=%h lo=%h dz=%b wanted 0/80000000/0", hi, lo, div_zero);
        end
        // Mixed random traffic; the scoreboard checks the values
        for (int i = 0; i < 8; i++) begin
            r_op = 2'(i % 4);
            r_a  = $urandom;
            r_b  = (i >= 4) ? W'($urandom_range(1, 1000)) : $urandom;
            if (i == 6) r_b = -r_b;
            issue(r_op, r_a, r_b, 1'b1);
            wait_done(lat, bok);
            checks++; if (lat !== ((r_op[1] && r_b == '0) ? 1 : 33)) begin
                errors++; $display("FAIL rand_latency op=%0d got %0d wanted 33", r_op, lat);
            end
        end
    endtask

    task automatic test_abort();
        bit bok;
        bit seen;
        // Run a tracked op so HI/LO hold a known value
        issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1);
        begin
            int lat; bit b2;
            wait_done(lat, b2);
        end
        bok = 1'b1;
        issue(2'b00, 32'd1234, 32'd5678, 1'b0);
        repeat (8) begin @(negedge clk); if (!busy) bok = 1'b0; end
        op = 2'b01; a = 32'd99; b = 32'd99; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (!busy) bok = 1'b0;
        repeat (9) begin @(negedge clk); if (!busy) bok = 1'b0; end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL abort_busy_before got low wanted high"); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_idle got busy=%b done=%b wanted 0/0", busy, done);
        end
        checks++; if (hi !== last_hi || lo !== last_lo) begin
            errors++; $display("FAIL abort_hilo got %h/%h wanted %h/%h", hi, lo, last_hi, last_lo);
        end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done got done wanted none"); end

        // abort landing on the FIX cycle wins over the HI/LO write
        issue(2'b01, 32'd3, 32'd5, 1'b0);
        repeat (32) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fix_busy got %b wanted 1", busy); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (done !== 1'b0 || busy !== 1'b0 || hi !== last_hi || lo !== last_lo) begin
            errors++; $display("FAIL abort_fix got done=%b busy=%b hi=%h lo=%h wanted 0/0/%h/%h",
                               done, busy, hi, lo, last_hi, last_lo);
        end

        // abort in IDLE blocks a simultaneous start
        op = 2'b01; a = 32'd2; b = 32'd2; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        seen = busy;
        repeat (40) begin @(negedge clk); if (done || busy) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_idle_start got activity wanted none"); end
    endtask

    task automatic test_async_reset();
        int lat; bit bok;
        issue(2'b01, 32'd6, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            errors++; $display("FAIL async_reset got busy=%b done=%b hi=%h lo=%h wanted 0", busy, done, hi, lo);
        end
        last_hi = '0;
        last_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(2'b01, 32'd6, 32'd7, 1'b1);
        wait_done(lat, bok);
        checks++; if (lat !== 33 || hi !== 32'd0 || lo !== 32'd42) begin
            errors++; $display("FAIL post_reset got lat=%0d hi=%0d lo=%0d wanted 33/0/42", lat, hi, lo);
        end
    endtask

    task automatic test_width8();
        logic [1:0]    t_op[3] = '{2'b00, 2'b10, 2'b11};
        logic [W8-1:0] t_a[3]  = '{8'h80, 8'hF9, 8'd200};
        logic [W8-1:0] t_b[3]  = '{8'h80, 8'h02, 8'd7};
        logic [W8-1:0] t_hi[3] = '{8'h40, 8'hFF, 8'h04};
        logic [W8-1:0] t_lo[3] = '{8'h00, 8'hFD, 8'h1C};
        int lat;
        for (int i = 0; i < 3; i++) begin
            op8 = t_op[i]; a8 = t_a[i]; b8 = t_b[i]; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5;
            lat = -1;
            for (int k = 1; k <= 50; k++) begin
                @(negedge clk);
                if (done8) begin lat = k; break; end
            end
            checks++; if (lat !== 9) begin errors++; $display("FAIL w8_latency case %0d got %0d wanted 9", i, lat); end
            checks++; if (hi8 !== t_hi[i] || lo8 !== t_lo[i]) begin
                errors++; $display("FAIL w8_result case %0d got %h/%h wanted %h/%h", i, hi8, lo8, t_hi[i], t_lo[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_back_to_back();
        test_div_zero();
        test_div_signed();
        test_abort();
        test_async_reset();
        test_width8();
        repeat (2) @(negedge clk);
        checks++; if (sb_q.size() != 0) begin
            errors++; $display("FAIL sb_drain got %0d outstanding wanted 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
